// File: rtl/huffman_stream_packer.sv
// Huffman back end: maps symbols through a loadable code table and packs the
// variable-length codes MSB-first into OUT_W-bit words, with flush and error flags.
module huffman_stream_packer #(
  parameter int SYM_W        = 8,
  parameter int MAX_CODE_LEN = 16,
  parameter int OUT_W        = 32,
  parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1),
  parameter int CNT_W        = $clog2(OUT_W + 1)
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    tableWrite,
  input  logic [SYM_W-1:0]        tableAddr,
  input  logic [MAX_CODE_LEN-1:0] tableCode,
  input  logic [LEN_W-1:0]        tableLen,
  input  logic                    symValid,
  input  logic [SYM_W-1:0]        symData,
  output logic                    symReady,
  input  logic                    flush,
  output logic                    outValid,
  output logic [OUT_W-1:0]        outData,
  output logic [CNT_W-1:0]        outBits,
  output logic                    outLast,
  input  logic                    outReady,
  output logic                    codeErr,
  output logic                    tableErr
);

  localparam int ACC_W  = OUT_W + MAX_CODE_LEN - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int DEPTH  = 1 << SYM_W;
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    tail_q, tail_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_bits_q, out_bits_d;
  logic                    out_last_q, out_last_d;
  logic                    code_err_q, code_err_d;
  logic                    table_err_q, table_err_d;

  logic [MAX_CODE_LEN-1:0] code_mem [DEPTH];
  logic [LEN_W-1:0]        len_q [DEPTH];

  logic                    tab_we;
  logic [MAX_CODE_LEN-1:0] code_mask;
  logic [MAX_CODE_LEN-1:0] cur_code;
  logic [LEN_W-1:0]        cur_len;
  logic                    sym_ready;
  logic                    accept;
  logic                    out_free;
  logic                    emit_full;
  logic                    emit_tail;
  logic                    tail_done;
  logic [ACC_W-1:0]        full_shift;
  logic [ACC_W-1:0]        tail_bits;
  logic [ACC_W-1:0]        tail_shift;

  assign tab_we    = tableWrite && (state_q == IDLE);
  assign code_mask = ~({MAX_CODE_LEN{1'b1}} << tableLen);

  // Codes are stored pre-masked so the accumulator can OR them in directly.
  always_ff @(posedge clock) begin
    if (tab_we) begin
      code_mem[tableAddr] <= tableCode & code_mask;
    end
  end

  // Lengths need a reset so that every symbol starts out unused.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        len_q[i] <= '0;
      end
    end else if (tab_we) begin
      len_q[tableAddr] <= tableLen;
    end
  end

  assign cur_code = code_mem[symData];
  assign cur_len  = len_q[symData];

  assign sym_ready = resetN && (state_q != FLUSH) && (fill_q < OUT_W_F);
  assign accept    = symValid && sym_ready;
  assign out_free  = !out_valid_q || outReady;
  assign emit_full = (fill_q >= OUT_W_F) && out_free;
  assign emit_tail = (state_q == FLUSH) && !tail_q && (fill_q < OUT_W_F) && out_free;
  assign tail_done = tail_q && out_valid_q && outReady;

  // Valid bits sit right-aligned in the accumulator; bits above fill are stale.
  assign full_shift = acc_q >> (fill_q - OUT_W_F);
  assign tail_bits  = acc_q & ~({ACC_W{1'b1}} << fill_q);
  assign tail_shift = tail_bits << (OUT_W_F - fill_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    tail_d      = tail_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    code_err_d  = code_err_q;
    table_err_d = table_err_q;

    if (tableWrite && (state_q != IDLE)) begin
      table_err_d = 1'b1;
    end

    if (out_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      acc_d  = (acc_q << cur_len) | ACC_W'(cur_code);
      fill_d = fill_q + FILL_W'(cur_len);
      if (cur_len == '0) begin
        code_err_d = 1'b1;
      end
    end

    if (emit_full) begin
      out_valid_d = 1'b1;
      out_data_d  = full_shift[OUT_W-1:0];
      out_bits_d  = CNT_W'(OUT_W);
      out_last_d  = 1'b0;
      fill_d      = fill_q - OUT_W_F;
    end

    if (emit_tail) begin
      out_valid_d = 1'b1;
      out_data_d  = tail_shift[OUT_W-1:0];
      out_bits_d  = CNT_W'(fill_q);
      out_last_d  = 1'b1;
      fill_d      = '0;
      tail_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (tail_done) begin
          state_d = IDLE;
          tail_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      fill_q      <= '0;
      tail_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
      code_err_q  <= 1'b0;
      table_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
      code_err_q  <= code_err_d;
      table_err_q <= table_err_d;
    end
  end

  assign symReady = sym_ready;
  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outBits  = out_bits_q;
  assign outLast  = out_last_q;
  assign codeErr  = code_err_q;
  assign tableErr = table_err_q;

endmodule

// File: tb/tb_huffman_stream_packer.sv
// Scoreboard bench for huffman_stream_packer: a bit-queue model of the packed
// stream predicts every output word; a monitor compares words as they are consumed.
module tb_huffman_stream_packer;

  localparam int SYM_W = 8;
  localparam int MCL   = 8;
  localparam int OUT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetN = 1'b0;
  logic             tableWrite = 1'b0;
  logic [SYM_W-1:0] tableAddr = '0;
  logic [MCL-1:0]   tableCode = '0;
  logic [LEN_W-1:0] tableLen = '0;
  logic             symValid = 1'b0;
  logic [SYM_W-1:0] symData = '0;
  logic             symReady;
  logic             flush = 1'b0;
  logic             outValid;
  logic [OUT_W-1:0] outData;
  logic [CNT_W-1:0] outBits;
  logic             outLast;
  logic             outReady = 1'b0;
  logic             codeErr;
  logic             tableErr;

  huffman_stream_packer #(
    .SYM_W(SYM_W), .MAX_CODE_LEN(MCL), .OUT_W(OUT_W)
  ) dut (
    .clock(clock), .resetN(resetN),
    .tableWrite(tableWrite), .tableAddr(tableAddr), .tableCode(tableCode), .tableLen(tableLen),
    .symValid(symValid), .symData(symData), .symReady(symReady), .flush(flush),
    .outValid(outValid), .outData(outData), .outBits(outBits), .outLast(outLast),
    .outReady(outReady), .codeErr(codeErr), .tableErr(tableErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OUT_W-1:0] d;
    int               b;
    bit               l;
  } exp_t;

  // Reference model: table contents, pending bitstream, expected words and flags.
  bit [MCL-1:0] m_code [256];
  int           m_len  [256];
  bit           bq[$];
  exp_t         expq[$];
  bit           m_busy;
  bit           e_code_err;
  bit           e_table_err;
  int           last_cnt = 0;
  int           n_vec = 0;
  int           n_err = 0;
  int           rdy_mode = 0;

  localparam logic [7:0] SA = 8'h41, SB = 8'h42, SC = 8'h43, SD = 8'h44;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_code[i] = '0;
      m_len[i]  = 0;
    end
    bq.delete();
    expq.delete();
    m_busy      = 1'b0;
    e_code_err  = 1'b0;
    e_table_err = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] s);
    exp_t e;
    if (m_len[s] == 0) e_code_err = 1'b1;
    for (int i = m_len[s] - 1; i >= 0; i--) bq.push_back(m_code[s][i]);
    while (bq.size() >= OUT_W) begin
      e.d = '0;
      for (int i = 0; i < OUT_W; i++) e.d[OUT_W-1-i] = bq.pop_front();
      e.b = OUT_W;
      e.l = 1'b0;
      expq.push_back(e);
    end
    m_busy = 1'b1;
  endtask

  task automatic model_flush();
    exp_t e;
    int   n;
    n   = bq.size();
    e.d = '0;
    for (int i = 0; i < n; i++) e.d[OUT_W-1-i] = bq.pop_front();
    e.b = n;
    e.l = 1'b1;
    expq.push_back(e);
    m_busy = 1'b1;
  endtask

  // Output-ready pattern: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      case (rdy_mode)
        0:       outReady = 1'b0;
        1:       outReady = 1'b1;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clock) begin
    if (resetN && outValid && outReady) begin
      $display("word data=0x%02h bits=%0d last=%0d", outData, outBits, outLast);
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h bits=%0d, required no word", outData, outBits);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("word_data", 32'(outData), 32'(e.d));
        chk("word_bits", 32'(outBits), 32'(e.b));
        chk("word_last", 32'(outLast), 32'(e.l));
      end
      if (outLast) begin
        last_cnt++;
        m_busy = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    resetN = 1'b0;
    #1;
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_symReady", 32'(symReady), 0);
    chk("rst_outLast",  32'(outLast), 0);
    chk("rst_outBits",  32'(outBits), 0);
    chk("rst_outData",  32'(outData), 0);
    chk("rst_codeErr",  32'(codeErr), 0);
    chk("rst_tableErr", 32'(tableErr), 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  task automatic write_tab(input logic [7:0] a, input logic [7:0] c, input int l);
    tableWrite = 1'b1;
    tableAddr  = a;
    tableCode  = c;
    tableLen   = LEN_W'(l);
    @(negedge clock);
    if (m_busy) begin
      e_table_err = 1'b1;
    end else begin
      m_code[a] = c & 8'((32'd1 << l) - 1);
      m_len[a]  = l;
    end
    @(posedge clock);
    #1;
    tableWrite = 1'b0;
  endtask

  task automatic send(input logic [7:0] s, input bit with_flush);
    bit done;
    done     = 1'b0;
    symValid = 1'b1;
    symData  = s;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      if (symReady) begin
        model_accept(s);
        done = 1'b1;
        if (with_flush) begin
          flush = 1'b1;
          model_flush();
        end
      end
      @(posedge clock);
      #1;
    end
    symValid = 1'b0;
    flush    = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: symReady stayed 0, required 1 within 300 cycles");
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clock);
    model_flush();
    @(posedge clock);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_last(input int target);
    for (int k = 0; k < 2000 && last_cnt < target; k++) begin
      @(posedge clock);
      #1;
    end
    if (last_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL last_timeout: last words seen %0d, required %0d", last_cnt, target);
    end
  endtask

  task automatic load_abcd();
    write_tab(SA, 8'h00, 1);
    write_tab(SB, 8'h02, 2);
    write_tab(SC, 8'h06, 3);
    write_tab(SD, 8'h07, 3);
  endtask

  initial begin
    int lc;
    model_reset();
    apply_reset();

    // Basic packing: A B C D A then flush.
    rdy_mode = 1;
    load_abcd();
    lc = last_cnt;
    send(SA, 0); send(SB, 0); send(SC, 0); send(SD, 0); send(SA, 0);
    do_flush();
    wait_last(lc + 1);
    write_tab(8'h45, 8'h01, 2);
    chk("idle_after_tail_tableErr", 32'(tableErr), 32'(e_table_err));

    // Backpressure: word held while outReady is low.
    rdy_mode = 0;
    @(posedge clock); #1;
    send(SA, 0); send(SB, 0); send(SC, 0); send(SD, 0);
    @(negedge clock);
    chk("bp_symReady_low", 32'(symReady), 0);
    chk("bp_outValid_late", 32'(outValid), 0);
    @(negedge clock);
    chk("bp_outValid", 32'(outValid), 1);
    chk("bp_symReady_after_emit", 32'(symReady), 1);
    @(posedge clock); #1;
    rdy_mode = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("bp_symReady_return", 32'(symReady), 1);
    lc = last_cnt;
    do_flush();
    wait_last(lc + 1);

    // Unwritten symbol sets codeErr and contributes no bits.
    apply_reset();
    lc = last_cnt;
    send(8'h00, 0);
    do_flush();
    wait_last(lc + 1);
    chk("unused_codeErr", 32'(codeErr), 32'(e_code_err));

    // Table write while streaming is dropped; symbol and flush in the same cycle.
    apply_reset();
    write_tab(SA, 8'h00, 1);
    lc = last_cnt;
    send(SA, 0);
    write_tab(SA, 8'h1F, 5);
    chk("run_write_tableErr", 32'(tableErr), 32'(e_table_err));
    send(SA, 1);
    wait_last(lc + 1);

    // Flush of an empty stream.
    apply_reset();
    lc = last_cnt;
    do_flush();
    wait_last(lc + 1);

    // Reset during FLUSH with a word pending.
    apply_reset();
    rdy_mode = 0;
    load_abcd();
    send(SA, 0); send(SB, 0); send(SC, 0); send(SD, 0);
    do_flush();
    write_tab(SB, 8'h01, 1);
    repeat (2) @(posedge clock);
    #1;
    chk("pre_rst_outValid", 32'(outValid), 1);
    chk("pre_rst_tableErr", 32'(tableErr), 32'(e_table_err));
    apply_reset();
    rdy_mode = 1;
    lc = last_cnt;
    send(SA, 0);
    do_flush();
    wait_last(lc + 1);
    chk("cleared_table_codeErr", 32'(codeErr), 32'(e_code_err));

    // Randomized stream with random backpressure and flushes.
    apply_reset();
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) begin
      write_tab(8'(i), 8'($urandom), int'($urandom_range(1, MCL)));
    end
    for (int n = 0; n < 400; n++) begin
      bit wf;
      logic [7:0] s;
      s  = 8'($urandom_range(0, 15));
      wf = ($urandom_range(0, 29) == 0);
      lc = last_cnt;
      send(s, wf);
      if (wf) begin
        wait_last(lc + 1);
      end else if ($urandom_range(0, 39) == 0) begin
        do_flush();
        wait_last(lc + 1);
      end
    end
    lc = last_cnt;
    do_flush();
    wait_last(lc + 1);
    chk("rand_codeErr", 32'(codeErr), 32'(e_code_err));
    chk("rand_tableErr", 32'(tableErr), 32'(e_table_err));
    chk("rand_words_left", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
